// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous first-word fall-through FIFO with occupancy flags
module fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH+1:0] word_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_M1  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_en, rd_en;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= CNT_ONE);
  assign almost_full  = (count_q >= DEPTH_M1);
  assign word_count   = {1'b0, count_q};
  assign r_data       = mem_q[rd_ptr_q];

  // When full, a simultaneous read frees the slot the write lands in.
  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_en && !rd_en)      count_d = count_q + CNT_ONE;
    else if (rd_en && !wr_en) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; the empty flag keeps stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en && reset) mem_q[wr_ptr_q] <= w_data;
  end

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - scoreboard bench for fifo with directed and random traffic
module tb_fifo;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd, wr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          empty, full, almost_empty, almost_full;
  logic [AW+1:0] word_count;

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [DW-1:0] exp_q[$];

  fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data),
    .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    check("word_count", int'(word_count), mcount);
    check("empty", int'(empty), int'(mcount == 0));
    check("full", int'(full), int'(mcount == DEPTH));
    check("almost_empty", int'(almost_empty), int'(mcount <= 1));
    check("almost_full", int'(almost_full), int'(mcount >= DEPTH - 1));
  endtask

  // One clock of traffic; the reference model decides what the FIFO accepts.
  task automatic cycle(input logic r, input logic w, input logic [DW-1:0] d);
    bit racc, wacc;
    racc = r && (mcount > 0);
    wacc = w && ((mcount < DEPTH) || r);
    rd = r;
    wr = w;
    w_data = d;
    if (wacc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    mcount = mcount + int'(wacc) - int'(racc);
    check_flags();
  endtask

  task automatic idle();
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    #2;
    reset = 1'b0;
    exp_q.delete();
    mcount = 0;
    #1;
    check_flags();
  endtask

  // Monitor: every accepted read must present the oldest outstanding word.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset && rd && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_data_underflow actual %0d required none at %0t", r_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("r_data", int'(r_data), int'(e));
        end
      end
    end
  end

  initial begin
    int p;
    reset = 1'b0;
    idle();
    w_data = '0;
    #12;
    check_flags();
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, DW'(i));
    repeat (2) cycle(1'b0, 1'b1, 4'hA);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, DW'(i + 8));
    apply_reset();
    wr = 1'b1;
    w_data = 4'h7;
    @(posedge clk);
    #1;
    check_flags();
    idle();
    reset = 1'b1;
    cycle(1'b0, 1'b1, 4'h5);
    cycle(1'b1, 1'b0, '0);

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, DW'(i + 12));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'(i));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 4'h6);
    cycle(1'b1, 1'b0, '0);

    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, DW'($urandom));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'($urandom));

    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        apply_reset();
        @(negedge clk);
        reset = 1'b1;
      end
      p = ((k / 200) % 2 == 1) ? 80 : 25;
      cycle(($urandom % 100) >= p, ($urandom % 100) < p, DW'($urandom));
    end

    while (mcount > 0) cycle(1'b1, 1'b0, '0);
    idle();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
